hc595_chain_ctrl: RTL



---
 rtl/hc595_pkg.sv | 7 +
 rtl/hc595_bit_timer.sv | 47 ++++
 rtl/hc595_chain_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hc595_pkg.sv
// Shared FSM state type and default constants for the 74HC595 chain controller.
package hc595_pkg;
  localparam int HC595_BITS_PER_CHIP = 8;
  localparam int DEFAULT_CLK_DIV     = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} hc595_state_t;
endpackage

// File: rtl/hc595_bit_timer.sv
// Phase/bit counters for the 595 serialiser; strobes are combinational off the counters.
// bit_start marks the last cycle of a bit period, shcp_rise the last cycle of its low half.
module hc595_bit_timer #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_start,
  output logic shcp_rise,
  output logic last_bit
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic [PW-1:0] phase;
  logic [BW-1:0] bit_idx;
  logic          period_end;

  assign period_end = (phase == PH_LAST);
  assign last_bit   = (bit_idx == BIT_LAST);
  assign bit_start  = en && period_end;
  assign shcp_rise  = en && (phase == PH_HALF);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase   <= '0;
      bit_idx <= '0;
    end else if (clr) begin
      phase   <= '0;
      bit_idx <= '0;
    end else if (en) begin
      if (period_end) begin
        phase   <= '0;
        // wrapping here leaves both counters at zero for the latch phase
        bit_idx <= last_bit ? '0 : bit_idx + BW'(1);
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end
endmodule

// File: rtl/hc595_chain_ctrl.sv
// Serialises a DATA_W word onto a 595 chain (ds/shcp) then pulses stcp; done DATA_W*CLK_DIV+CLK_DIV/2+1 cycles after accept.
// din_ready is low for the whole shift/latch; auto_mode replays the held word when nothing new is offered.
module hc595_chain_ctrl
  import hc595_pkg::*;
#(
  parameter int DATA_W    = 2 * HC595_BITS_PER_CHIP,
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              auto_mode,
  input  logic              blank,
  output logic              busy,
  output logic              done,
  output logic              ds,
  output logic              shcp,
  output logic              stcp,
  output logic              oe
);
  hc595_state_t      state;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] hold;
  logic              hold_vld;
  logic              latched;
  logic              oe_q;
  logic              accept;
  logic              start;
  logic [DATA_W-1:0] start_word;
  logic              bit_start;
  logic              shcp_rise;
  logic              last_bit;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // A freshly offered word always beats an auto-refresh replay.
  always_comb begin
    accept     = 1'b0;
    start      = 1'b0;
    start_word = hold;
    if (state == IDLE) begin
      if (din_valid && din_ready) begin
        accept     = 1'b1;
        start      = 1'b1;
        start_word = din;
      end else if (auto_mode && hold_vld) begin
        start = 1'b1;
      end
    end
  end

  hc595_bit_timer #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (start),
    .en        (state != IDLE),
    .bit_start (bit_start),
    .shcp_rise (shcp_rise),
    .last_bit  (last_bit)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ds        <= 1'b0;
      shcp      <= 1'b0;
      stcp      <= 1'b0;
      sreg      <= '0;
      hold      <= '0;
      hold_vld  <= 1'b0;
      latched   <= 1'b0;
      oe_q      <= 1'b1;
    end else begin
      done <= 1'b0;
      oe_q <= latched ? blank : 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            din_ready <= 1'b0;
            shcp      <= 1'b0;
            ds        <= first_bit(start_word);
            sreg      <= advance(start_word);
            if (accept) begin
              hold     <= din;
              hold_vld <= 1'b1;
            end
          end else begin
            din_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_start && last_bit) begin
            state <= LATCH;
            ds    <= 1'b0;
            shcp  <= 1'b0;
            stcp  <= 1'b1;
          end else if (bit_start) begin
            ds   <= first_bit(sreg);
            sreg <= advance(sreg);
            shcp <= 1'b0;
          end else if (shcp_rise) begin
            shcp <= 1'b1;
          end
        end
        LATCH: begin
          if (shcp_rise) begin
            state     <= IDLE;
            stcp      <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            din_ready <= 1'b1;
            latched   <= 1'b1;
            oe_q      <= blank;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oe = oe_q | ~sys_rst_n;
endmodule
